// File: rtl/ifu_pkg.sv
// ifu_pkg: shared widths, reset PC, FSM state and error-code encodings for the fetch unit
package ifu_pkg;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] PC_START = 64'h0000_0000_8000_0000;
  typedef enum logic [2:0] {
    IFU_IDLE = 3'd0,
    IFU_REQ  = 3'd1,
    IFU_WAIT = 3'd2,
    IFU_HOLD = 3'd3,
    IFU_ERR  = 3'd4
  } ifu_state_e;
  typedef enum logic [1:0] {
    IFU_ERR_NONE     = 2'b00,
    IFU_ERR_BUS      = 2'b01,
    IFU_ERR_MISALIGN = 2'b10
  } ifu_err_e;
  function automatic logic aligned(input logic [ADDR_W-1:0] a);
    return a[1:0] == 2'b00;
  endfunction
endpackage

// File: rtl/ifu_if.sv
// ifu_if: request/grant/response bus between the fetch unit and instruction memory
interface ifu_if;
  import ifu_pkg::*;
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;
  modport master (output req, addr, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/ifu_pc_reg.sv
// pc_reg: architectural PC register, async reset to PC_START with load enable
module pc_reg
  import ifu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic [ADDR_W-1:0] pc_o
);
  logic [ADDR_W-1:0] pc_q, pc_d;
  assign pc_d = load_i ? data_i : pc_q;
  // hold the PC until a load is requested
  always_ff @(posedge clk or posedge rst)
    if (rst) pc_q <= PC_START;
    else     pc_q <= pc_d;
  assign pc_o = pc_q;
endmodule

// File: rtl/ifu.sv
// ifu: fetches one instruction at a time and hands it to decode with pc/snpc
module ifu
  import ifu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  ifu_if.master             imem,
  input  logic [ADDR_W-1:0] dnpc_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] snpc_o,
  output logic [63:0]       inst_cnt_o,
  output logic              err_o,
  output logic [1:0]        err_code_o
);
  ifu_state_e        state_q;
  logic [DATA_W-1:0] inst_q;
  logic [63:0]       cnt_q;
  ifu_err_e          err_code_q;
  logic [ADDR_W-1:0] pc;
  logic              pc_load;
  assign pc_load = (state_q == IFU_HOLD) && inst_ready_i && aligned(dnpc_i);
  pc_reg u_pc (
    .clk    (clk),
    .rst    (rst),
    .load_i (pc_load),
    .data_i (dnpc_i),
    .pc_o   (pc)
  );
  // fetch FSM with instruction latch, accepted-instruction counter and sticky error code
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IFU_IDLE;
      inst_q     <= '0;
      cnt_q      <= '0;
      err_code_q <= IFU_ERR_NONE;
    end else begin
      case (state_q)
        IFU_IDLE: state_q <= IFU_REQ;
        IFU_REQ:  if (imem.gnt) state_q <= IFU_WAIT;
        IFU_WAIT:
          if (imem.rvalid) begin
            if (imem.err) begin
              state_q    <= IFU_ERR;
              err_code_q <= IFU_ERR_BUS;
            end else begin
              inst_q  <= imem.rdata;
              state_q <= IFU_HOLD;
            end
          end
        IFU_HOLD:
          if (inst_ready_i) begin
            cnt_q <= cnt_q + 64'd1;
            if (aligned(dnpc_i)) state_q <= IFU_REQ;
            else begin
              state_q    <= IFU_ERR;
              err_code_q <= IFU_ERR_MISALIGN;
            end
          end
        default: state_q <= IFU_ERR;
      endcase
    end
  assign imem.req     = state_q == IFU_REQ;
  assign imem.addr    = pc;
  assign inst_valid_o = state_q == IFU_HOLD;
  assign err_o        = state_q == IFU_ERR;
  assign err_code_o   = err_code_q;
  assign inst_o       = inst_q;
  assign inst_cnt_o   = cnt_q;
  assign pc_o         = pc;
  assign snpc_o       = pc + 64'd4;
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: table-driven fetch transactions with a scoreboard of expected pc/inst pairs
module tb_ifu;
  import ifu_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] dnpc = '0;
  logic        ready = 1'b0;
  logic        valid, err;
  logic [31:0] inst;
  logic [63:0] pc, snpc, cnt;
  logic [1:0]  code;
  ifu_if imem();
  ifu dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (imem),
    .dnpc_i       (dnpc),
    .inst_valid_o (valid),
    .inst_ready_i (ready),
    .inst_o       (inst),
    .pc_o         (pc),
    .snpc_o       (snpc),
    .inst_cnt_o   (cnt),
    .err_o        (err),
    .err_code_o   (code)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0;
  int errors = 0;
  int last_fire = 0;
  typedef struct {
    bit          pre_rst;
    logic [63:0] addr;
    logic [31:0] word;
    int          gd;
    int          rd;
    int          yd;
    logic [63:0] dnpc;
    bit          berr;
    bit          tp;
    logic [63:0] cnt;
    logic [1:0]  code;
  } vec_t;
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;
  vec_t vecs[11];
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {63'd0, act}, {63'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    chk1("rst_req", imem.req, 1'b0);
    chk1("rst_valid", valid, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk("rst_code", {62'd0, code}, 64'd0);
    chk("rst_addr", imem.addr, PC_START);
    chk("rst_pc", pc, PC_START);
    chk("rst_snpc", snpc, PC_START + 64'd4);
    chk("rst_inst", {32'd0, inst}, 64'd0);
    chk("rst_cnt", cnt, 64'd0);
  endtask

  task automatic do_reset();
    #3 rst = 1'b1;
    imem.gnt = 1'b0;
    imem.rvalid = 1'b0;
    ready = 1'b0;
    #1 check_reset();
    sb.delete();
    rst = 1'b0;
    step();
    chk1("restart_req", imem.req, 1'b1);
    chk("restart_addr", imem.addr, PC_START);
  endtask

  task automatic err_idle(input logic [63:0] held_pc);
    chk1("err_flag", err, 1'b1);
    chk("err_pc_held", pc, held_pc);
    for (int i = 0; i < 3; i++) begin
      imem.gnt = 1'b1;
      step();
      chk1("err_no_req", imem.req, 1'b0);
      chk1("err_no_valid", valid, 1'b0);
    end
    imem.gnt = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    if (v.pre_rst) do_reset();
    chk1("req", imem.req, 1'b1);
    chk("addr", imem.addr, v.addr);
    chk1("req_valid", valid, 1'b0);
    for (int i = 0; i < v.gd; i++) begin
      imem.gnt = 1'b0;
      step();
      chk1("req_stall", imem.req, 1'b1);
      chk("addr_stable", imem.addr, v.addr);
    end
    imem.gnt = 1'b1;
    step();
    imem.gnt = 1'b0;
    chk1("wait_req", imem.req, 1'b0);
    chk1("wait_valid", valid, 1'b0);
    for (int i = 0; i < v.rd; i++) begin
      step();
      chk1("wait_stall_valid", valid, 1'b0);
      chk1("wait_stall_req", imem.req, 1'b0);
    end
    imem.rvalid = 1'b1;
    imem.rdata = v.word;
    imem.err = v.berr;
    if (!v.berr) sb.push_back('{v.addr, v.word});
    step();
    imem.rvalid = 1'b0;
    imem.err = 1'b0;
    imem.rdata = '0;
    if (v.berr) begin
      chk1("berr_valid", valid, 1'b0);
      chk("berr_code", {62'd0, code}, {62'd0, v.code});
      chk("berr_cnt", cnt, v.cnt);
      err_idle(v.addr);
      return;
    end
    chk1("hold_valid", valid, 1'b1);
    for (int i = 0; i < v.yd; i++) begin
      ready = 1'b0;
      step();
      chk1("hold_stall_valid", valid, 1'b1);
      chk("hold_stable_inst", {32'd0, inst}, {32'd0, sb[0].inst});
      chk("hold_stable_pc", pc, sb[0].pc);
      chk("hold_no_cnt", cnt, v.cnt - 64'd1);
    end
    ready = 1'b1;
    dnpc = v.dnpc;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_underflow: got empty scoreboard expected one entry");
    end else begin
      e = sb.pop_front();
      chk("inst", {32'd0, inst}, {32'd0, e.inst});
      chk("pc", pc, e.pc);
      chk("snpc", snpc, e.pc + 64'd4);
    end
    step();
    ready = 1'b0;
    if (v.tp) chk("throughput", 64'(cyc - last_fire), 64'd3);
    last_fire = cyc;
    chk("cnt", cnt, v.cnt);
    chk("code", {62'd0, code}, {62'd0, v.code});
    chk1("post_valid", valid, 1'b0);
    if (v.code != 2'b00) err_idle(v.addr);
    else begin
      chk1("post_err", err, 1'b0);
      chk1("next_req", imem.req, 1'b1);
      chk("next_addr", imem.addr, v.dnpc);
    end
  endtask

  initial begin
    vecs[0]  = '{0, 64'h8000_0000, 32'h0000_0413, 0, 0, 0, 64'h8000_0004, 0, 0, 64'd1, 2'b00};
    vecs[1]  = '{0, 64'h8000_0004, 32'h0010_0093, 0, 0, 0, 64'h8000_0008, 0, 1, 64'd2, 2'b00};
    vecs[2]  = '{0, 64'h8000_0008, 32'h0020_0113, 0, 0, 0, 64'h8000_000C, 0, 1, 64'd3, 2'b00};
    vecs[3]  = '{0, 64'h8000_000C, 32'h0030_0193, 0, 0, 0, 64'h8000_0010, 0, 1, 64'd4, 2'b00};
    vecs[4]  = '{0, 64'h8000_0010, 32'h0040_0213, 2, 3, 4, 64'h8000_0014, 0, 0, 64'd5, 2'b00};
    vecs[5]  = '{0, 64'h8000_0014, 32'h0000_006F, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 64'd6, 2'b00};
    vecs[6]  = '{0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_8067, 0, 0, 0, 64'h8000_1000, 0, 1, 64'd7, 2'b00};
    vecs[7]  = '{0, 64'h8000_1000, 32'h0050_0293, 0, 1, 0, 64'h8000_1002, 0, 0, 64'd8, 2'b10};
    vecs[8]  = '{1, 64'h8000_0000, 32'h0000_0013, 1, 0, 0, 64'h8000_0004, 1, 0, 64'd0, 2'b01};
    vecs[9]  = '{1, 64'h8000_0000, 32'h0000_0413, 0, 0, 0, 64'h8000_0004, 0, 0, 64'd1, 2'b00};
    vecs[10] = '{0, 64'h8000_0000, 32'h00A0_0513, 0, 0, 1, 64'h8000_0004, 0, 0, 64'd1, 2'b00};
    imem.gnt = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata = '0;
    imem.err = 1'b0;
    repeat (2) step();
    check_reset();
    rst = 1'b0;
    step();
    for (int i = 0; i < 10; i++) run_vec(vecs[i]);
    imem.gnt = 1'b1;
    step();
    imem.gnt = 1'b0;
    chk1("mid_wait_req", imem.req, 1'b0);
    #3 rst = 1'b1;
    #1 check_reset();
    sb.delete();
    imem.rvalid = 1'b1;
    imem.rdata = 32'hDEAD_BEEF;
    step();
    rst = 1'b0;
    step();
    chk1("stale_idle_req", imem.req, 1'b1);
    chk1("stale_idle_valid", valid, 1'b0);
    chk("stale_idle_addr", imem.addr, PC_START);
    step();
    chk1("stale_req_req", imem.req, 1'b1);
    chk1("stale_req_valid", valid, 1'b0);
    imem.rvalid = 1'b0;
    imem.rdata = '0;
    run_vec(vecs[10]);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the NPC core; sits directly upstream of decode/`execute`. It owns the architectural PC, resets it to `PC_START`, fetches one 32-bit instruction at a time over a request/grant/response interface to instruction memory, and presents it with `pc`/`snpc` to decode through a valid/ready handshake. On handshake it loads the PC from the `dnpc` computed by `execute`. It also maintains a retired-fetch counter for perf/difftest.

## Interface
- No parameters; widths from `defines.v`: `INST_ADDR_BUS` = 64 bits, `INST_DATA_BUS` = 32 bits.
- Clocking: one clock; reset is asynchronous and active-high.
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `dnpc_i`  in  64  next PC from `execute`, valid while `inst_valid_o` is high.
- `imem_req_o`  out  1  fetch request.
- `imem_addr_o`  out  64  fetch address (= pc).
- `imem_gnt_i`  in  1  memory accepts the request this cycle.
- `imem_rvalid_i`  in  1  response valid.
- `imem_rdata_i`  in  32  instruction word.
- `imem_err_i`  in  1  bus error; qualified by `imem_rvalid_i`.
- `inst_valid_o`  out  1  instruction available to decode.
- `inst_ready_i`  in  1  decode accepts it.
- `inst_o`  out  32  fetched instruction.
- `pc_o`  out  64  address of `inst_o`.
- `snpc_o`  out  64  `pc_o + 4`.
- `inst_cnt_o`  out  64  number of accepted instructions.
- `err_o`  out  1  sticky fault flag.
- `err_code_o`  out  2  `01` bus error, `10` misaligned dnpc, `00` none.

## Operation
- States: IDLE, REQ, WAIT, HOLD, ERR.
- IDLE: reset state. Next cycle goes to REQ unconditionally.
- REQ: `imem_req_o=1`, `imem_addr_o=pc`. Addr is stable until grant. On `imem_gnt_i` goes to WAIT; otherwise stays in REQ. `imem_rvalid_i` is ignored in REQ.
- WAIT: waits for `imem_rvalid_i`.
  - rvalid & !err: latch `imem_rdata_i` into `inst_o`, go to HOLD.
  - rvalid & err: set `err_code_o=01`, go to ERR.
- HOLD: `inst_valid_o=1`. `inst_o`, `pc_o`, `snpc_o` are held stable until fire (`inst_valid_o & inst_ready_i`).
  - Fire with `dnpc_i[1:0]==0`: pc <= `dnpc_i`, `inst_cnt_o` += 1, go to REQ.
  - Fire with `dnpc_i[1:0]!=0`: `inst_cnt_o` += 1, pc unchanged, `err_code_o=10`, go to ERR.
- ERR: `err_o=1`, no requests, `inst_valid_o=0`. Exits only via `rst`.
- `snpc_o = pc + 4`, modulo 2^64; wraps at the top of the address space without a flag.
- `inst_cnt_o` wraps modulo 2^64.
- `imem_rvalid_i` outside WAIT is a protocol violation and is ignored.
- `imem_gnt_i` outside REQ is ignored.

## Timing
- Reset values, asserted immediately and asynchronously:
  - state=IDLE, pc=`PC_START`, `inst_o=0`, `inst_cnt_o=0`.
  - `err_o=0`, `err_code_o=00`.
  - `imem_req_o=0`, `inst_valid_o=0`.
  - `imem_addr_o`/`pc_o=PC_START`, `snpc_o=PC_START+4`.
- All outputs are registered or decoded from the state register only. No input-to-output combinational path.
- Zero-wait memory: REQ (gnt) at N → WAIT (rvalid) at N+1 → HOLD at N+2 → REQ at N+3 when `inst_ready_i` is high at N+2. Throughput is 1 instruction / 3 cycles.
- Each cycle of `imem_gnt_i` low extends REQ by one cycle. Each cycle of `imem_rvalid_i` low extends WAIT. Each cycle of `inst_ready_i` low extends HOLD.
- Reset mid-transaction aborts the fetch. Instruction memory shares `rst`, so no stale response survives reset.

## Structure
- Add to `defines.v`:
  - `IFU_STATE_BUS` (2:0) and state encodings `IFU_IDLE`/`IFU_REQ`/`IFU_WAIT`/`IFU_HOLD`/`IFU_ERR`.
  - `IFU_ERR_NONE`/`IFU_ERR_BUS`/`IFU_ERR_MISALIGN`.
  - Reuse `PC_START` and `INST_ADDR_BUS`.
- One sub-module: `pc_reg`, a 64-bit register with async reset to `PC_START`, load enable and load data. `ifu` contains the FSM, instruction latch, counter and error logic.

## Test plan
- Reset release, memory returns `0x00000413` with zero wait, `inst_ready_i=1`:
  - first `imem_addr_o=0x80000000` with req high 1 cycle after reset deassert;
  - `inst_valid_o` 2 cycles after grant with `pc_o=0x80000000`, `snpc_o=0x80000004`.
- Sequential fetch with `dnpc_i=snpc_o` for 4 instructions: addresses 0x80000000/04/08/0C, `inst_cnt_o=4`, one fire per 3 cycles.
- Backpressure and stalls: grant delayed 2 cycles, rvalid delayed 3 cycles, `inst_ready_i` low 4 cycles in HOLD. Addr is stable during the grant wait and inst/pc are stable during HOLD; one fire only.
- Jump: fire with `dnpc_i=0x80001000` → next request address 0x80001000. Fire with `dnpc_i=0x80001002` → `err_o=1`, `err_code_o=10`, no further requests, `inst_cnt_o` incremented.
- Bus error: rvalid with `imem_err_i=1` → ERR, `err_code_o=01`, `inst_valid_o` never asserted. Then `rst` pulse → outputs back to reset values and fetch restarts at 0x80000000.
- Async reset asserted mid-WAIT: outputs return to reset values before the next clock edge, and a stale rvalid during IDLE/REQ is ignored.
